// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready word output, flush and sticky overrun.
// Optional SIPO_PARITY_EN: frames carry a trailing even-parity bit and parity_err is reported.
module sipo_deser #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
`ifdef SIPO_PARITY_EN
   parameter int unsigned CW        = $clog2(WIDTH + 2)
`else
   parameter int unsigned CW        = $clog2(WIDTH + 1)
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             flush,
   input  logic             word_ready,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic [CW-1:0]    bit_count,
   output logic             overrun
`ifdef SIPO_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] new_word;
   logic             complete;
`ifdef SIPO_PARITY_EN
   logic             perr_q, perr_d;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state: flush beats bit_valid; the word handshake runs every cycle
   always_comb begin
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      complete = 1'b0;
      shifted  = shreg_q;
`ifdef SIPO_PARITY_EN
      perr_d   = perr_q;
`endif

      if (MSB_FIRST) begin
         shifted = {shreg_q[WIDTH-2:0], bit_in};
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) shifted[i] = bit_in;
         end
      end

`ifdef SIPO_PARITY_EN
      // The parity edge completes the frame; data bits are already all in shreg_q
      new_word = shreg_q;
`else
      new_word = shifted;
`endif

      if (valid_q && word_ready) valid_d = 1'b0;

      if (flush) begin
         shreg_d = '0;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else if (bit_valid) begin
         complete = (cnt_q == LAST);
         cnt_d    = complete ? '0 : cnt_q + CW'(1);
`ifdef SIPO_PARITY_EN
         if (!complete) shreg_d = shifted;
`else
         shreg_d = shifted;
`endif
         if (complete) begin
            if (!valid_q || word_ready) begin
               word_d  = new_word;
               valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
               perr_d  = (^shreg_q) ^ bit_in;
`endif
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   assign word       = word_q;
   assign word_valid = valid_q;
   assign bit_count  = cnt_q;
   assign overrun    = ovr_q;
`ifdef SIPO_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer. Collects WIDTH valid serial bits into one word and presents it on a registered output with a valid/ready handshake.
- Supports MSB-first or LSB-first ordering, a per-bit qualifier, a flush that discards a partial word, and sticky overrun detection.
- Sits between a bit-serial source (line receiver, test pattern generator) and a word-wide consumer.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in word[WIDTH-1]; 0: first received bit lands in word[0].
- CW, $clog2(WIDTH+1), width of bit_count (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- bit_in, input, 1, serial data bit.
- bit_valid, input, 1, bit_in is sampled only when this is 1.
- flush, input, 1, synchronous discard of the partial word.
- word_ready, input, 1, consumer accepts word this cycle.
- word, output, WIDTH, last completed word.
- word_valid, output, 1, word holds an unconsumed word.
- bit_count, output, CW, bits collected toward the current word (0..WIDTH-1).
- overrun, output, 1, sticky; a completed word was dropped.
- parity_err, output, 1, present only with SIPO_PARITY_EN (see below).

Behaviour:
- Reset (rst_n=0, asynchronous): shift register, bit_count, word, word_valid, overrun and parity_err are all 0.
- All other state changes occur on the clk rising edge.
- Priority per edge: flush, then bit_valid. A flush with bit_valid in the same cycle discards that bit.
- flush=1:
  - shift register and bit_count go to 0; overrun goes to 0.
  - word and word_valid are untouched, so a completed word survives a flush.
  - The word_ready handshake still applies that cycle.
- bit_valid=1, flush=0:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: bit_in is written to position bit_count.
  - bit_count increments.
- bit_valid=0: no shift and no count change; gaps of any length are allowed.
- Completion: an edge with bit_valid=1 and bit_count==WIDTH-1.
  - The assembled word, including the current bit_in, is available after that same edge. Latency is 0 cycles from the last bit.
  - bit_count wraps to 0. The shift register needs no clearing because every bit is rewritten.
- Handshake, on completion:
  - word_valid=0, or word_valid=1 with word_ready=1: word is loaded and word_valid=1.
  - word_valid=1 with word_ready=0: the new word is dropped, the old word is kept, and overrun is set to 1.
- Handshake, without completion: word_valid=1 with word_ready=1 clears word_valid. word keeps its value.
- word_ready while word_valid=0 has no effect.
- overrun is cleared only by rst_n or flush.
- Reset mid-word: the partial word is lost and the first bit after release starts a new word.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame length is WIDTH+1. The extra bit is sampled after the WIDTH data bits and is an even-parity bit over them.
  - bit_count range becomes 0..WIDTH and CW is $clog2(WIDTH+2).
  - Completion moves to the parity-bit edge.
  - parity_err port exists. It is loaded together with word (XOR of data bits ^ parity bit) and follows the same drop rule.
  - parity_err is reset to 0 and holds its value until the next load.
- Undefined: no parity_err port, and frames are exactly WIDTH bits.

Test Plan:
- Reset and MSB order: WIDTH=8, MSB_FIRST=1, rst_n pulse, then bits 1,0,1,1,0,0,1,0 with bit_valid=1 → word=8'hB2 and word_valid=1 after the 8th edge, bit_count=0.
- LSB order with gaps: MSB_FIRST=0, same bit sequence with bit_valid=0 on alternating cycles → word=8'h4D. bit_count holds during the gaps.
- Flush mid-word: 3 bits of 1, then flush=1 with bit_valid=1, then 8 bits of 0 → word=8'h00. The bit during the flush is ignored; an earlier word stays valid through the flush.
- Backpressure: word_ready=0, send 8'hB2 then 8'h0F → word stays 8'hB2 and overrun=1. A flush clears overrun; then word_ready=1 clears word_valid.
- Same-edge accept and complete: word_valid=1, word_ready=1 on the edge the 8th bit of 8'h5A arrives → word=8'h5A, word_valid stays 1, overrun=0.
- Reset mid-word and parity: assert rst_n=0 after 5 bits → all outputs 0 and bit_count=0. With SIPO_PARITY_EN, send 8'hB2 plus parity 0 → parity_err=0; send 8'hB2 plus parity 1 → parity_err=1.
